// File: rtl/traffic_sensor_pkg.sv
// Shared types and constants for the car-presence sensor conditioning path.
// Used by sensor_debounce and traffic_sensor_conditioner.
package traffic_sensor_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        QUAL_ON  = 2'd1,
        ACTIVE   = 2'd2,
        QUAL_OFF = 2'd3
    } sensor_state_t;

    localparam int CNT_W               = 8;
    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int HOLD_CYCLES_DEF     = 8;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// One sensor channel: 2-flop synchronizer, debounce FSM, rise strobe.
// Optional minimum-high hold built only when SENSOR_STRETCH_EN is defined.
module sensor_debounce
    import traffic_sensor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
`ifdef SENSOR_STRETCH_EN
  , parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic out,
    output logic rise
);

    localparam logic [CNT_W-1:0] DEB = CNT_W'(DEBOUNCE_CYCLES);

    logic             s1, s2;
    sensor_state_t    state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             fsm_on_next, out_next, rise_next;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= IDLE;
            cnt   <= '0;
            out   <= 1'b0;
            rise  <= 1'b0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            state <= state_next;
            cnt   <= cnt_next;
            out   <= out_next;
            rise  <= rise_next;
        end
    end

    // NOTE: defaults first so every path assigns every output; no latch is inferred.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (s2) begin
                    state_next = (DEB <= CNT_W'(1)) ? ACTIVE : QUAL_ON;
                    cnt_next   = (DEB <= CNT_W'(1)) ? '0 : CNT_W'(1);
                end
            end
            QUAL_ON: begin
                if (!s2) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (sat_inc(cnt) >= DEB) begin
                    state_next = ACTIVE;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = sat_inc(cnt);
                end
            end
            ACTIVE: begin
                if (!s2) begin
                    state_next = (DEB <= CNT_W'(1)) ? IDLE : QUAL_OFF;
                    cnt_next   = (DEB <= CNT_W'(1)) ? '0 : CNT_W'(1);
                end
            end
            QUAL_OFF: begin
                if (s2) begin
                    state_next = ACTIVE;
                    cnt_next   = '0;
                end else if (sat_inc(cnt) >= DEB) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = sat_inc(cnt);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

`ifdef SENSOR_STRETCH_EN
    localparam logic [CNT_W-1:0] HOLD = CNT_W'(HOLD_CYCLES);

    logic [CNT_W-1:0] hold, hold_next;

    always_ff @(posedge clk) begin
        if (reset) hold <= '0;
        else       hold <= hold_next;
    end
`endif

    // Output is registered from the next-state decode, so the rise strobe lines up with out.
    always_comb begin
        fsm_on_next = (state_next == ACTIVE) || (state_next == QUAL_OFF);
        rise_next   = fsm_on_next && !out;
`ifdef SENSOR_STRETCH_EN
        // A held output is already 1, so a renewed FSM rise neither reloads nor strobes.
        hold_next   = rise_next ? HOLD : ((hold != '0) ? hold - CNT_W'(1) : '0);
        out_next    = fsm_on_next || (hold_next != '0);
`else
        out_next    = fsm_on_next;
`endif
    end

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Conditions the raw street-A/B car sensors into clean Sa/Sb levels plus rise strobes.
// HOLD_CYCLES exists only when SENSOR_STRETCH_EN is defined.
module traffic_sensor_conditioner
    import traffic_sensor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
`ifdef SENSOR_STRETCH_EN
  , parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic sa_raw,
    input  logic sb_raw,
    output logic Sa,
    output logic Sb,
    output logic sa_rise,
    output logic sb_rise
);

    sensor_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef SENSOR_STRETCH_EN
      , .HOLD_CYCLES     (HOLD_CYCLES)
`endif
    ) u_sa (
        .clk   (clk),
        .reset (reset),
        .raw   (sa_raw),
        .out   (Sa),
        .rise  (sa_rise)
    );

    sensor_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef SENSOR_STRETCH_EN
      , .HOLD_CYCLES     (HOLD_CYCLES)
`endif
    ) u_sb (
        .clk   (clk),
        .reset (reset),
        .raw   (sb_raw),
        .out   (Sb),
        .rise  (sb_rise)
    );

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Self-checking bench for traffic_sensor_conditioner: directed scenarios plus random
// stimulus against a sample-history reference model (SENSOR_STRETCH_EN aware).
`timescale 1ns/1ps
module tb_traffic_sensor_conditioner;
    import traffic_sensor_pkg::*;

    localparam int D = DEBOUNCE_CYCLES_DEF;
`ifdef SENSOR_STRETCH_EN
    localparam int H = HOLD_CYCLES_DEF;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sa_raw = 1'b0;
    logic sb_raw = 1'b0;
    logic Sa, Sb, sa_rise, sb_rise;

    int errors = 0;
    int checks = 0;

    // Reference model: a level is accepted once the last D synchronized samples all agree.
    bit m_s1 [2];
    bit m_s2 [2];
    bit m_fsm [2];
    bit m_out [2];
    bit m_rise [2];
    int m_age [2];
    bit hist [2][$];

    always #5 clk = ~clk;

    traffic_sensor_conditioner #(
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sa_raw  (sa_raw),
        .sb_raw  (sb_raw),
        .Sa      (Sa),
        .Sb      (Sb),
        .sa_rise (sa_rise),
        .sb_rise (sb_rise)
    );

    task automatic model_step(input int c, input bit r);
        bit prev;
        int ones;
        if (reset) begin
            m_s1[c] = 0; m_s2[c] = 0; m_fsm[c] = 0;
            m_out[c] = 0; m_rise[c] = 0; m_age[c] = 0;
            hist[c].delete();
        end else begin
            hist[c].push_back(m_s2[c]);
            if (hist[c].size() > D) void'(hist[c].pop_front());
            if (hist[c].size() == D) begin
                ones = 0;
                for (int i = 0; i < D; i++) ones += int'(hist[c][i]);
                if (ones == D)      m_fsm[c] = 1;
                else if (ones == 0) m_fsm[c] = 0;
            end
            m_s2[c] = m_s1[c];
            m_s1[c] = r;
            prev = m_out[c];
`ifdef SENSOR_STRETCH_EN
            if (!prev) begin
                m_out[c] = m_fsm[c];
                m_age[c] = 0;
            end else begin
                m_age[c]++;
                m_out[c] = m_fsm[c] || (m_age[c] < H);
            end
`else
            m_out[c] = m_fsm[c];
`endif
            m_rise[c] = m_out[c] && !prev;
        end
    endtask

    task automatic tick();
        model_step(0, sa_raw);
        model_step(1, sb_raw);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] obs();
        return {Sa, Sb, sa_rise, sb_rise};
    endfunction

    function automatic logic [3:0] expv();
        return {m_out[0], m_out[1], m_rise[0], m_rise[1]};
    endfunction

    task automatic test_reset();
        int t_rise = 0;
        reset = 1; sa_raw = 1; sb_raw = 0;
        repeat (3) begin
            tick();
            if (Sa !== 1'b0 || sa_rise !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: Sa=%b sa_rise=%b, required 0 0", Sa, sa_rise);
            end
            checks++;
        end
        reset = 0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (t_rise == 0 && Sa === 1'b1) t_rise = i;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL reset_model: cycle %0d outputs=%b model=%b", i, obs(), expv());
            end
            checks++;
        end
        if (t_rise != D + 2) begin
            errors++;
            $display("FAIL reset_release_latency: Sa rose after %0d cycles, required %0d", t_rise, D + 2);
        end
        checks++;
        sa_raw = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL reset_settle: cycle %0d outputs=%b model=%b", i, obs(), expv());
            end
            checks++;
        end
    endtask

    task automatic test_clean_press();
        int t_rise = 0, t_fall = 0, strobes = 0;
        sb_raw = 1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (t_rise == 0 && Sb === 1'b1) t_rise = i;
            if (sb_rise === 1'b1) strobes++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL press_model: cycle %0d outputs=%b model=%b", i, obs(), expv());
            end
            checks++;
        end
        if (t_rise != D + 2 || strobes != 1) begin
            errors++;
            $display("FAIL press_rise: rise at %0d with %0d strobes, required %0d with 1", t_rise, strobes, D + 2);
        end
        checks++;
        sb_raw = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (t_fall == 0 && Sb === 1'b0) t_fall = i;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL release_model: cycle %0d outputs=%b model=%b", i, obs(), expv());
            end
            checks++;
        end
        if (t_fall != D + 2) begin
            errors++;
            $display("FAIL release_latency: Sb fell after %0d cycles, required %0d", t_fall, D + 2);
        end
        checks++;
    endtask

    task automatic test_glitch();
        bit saw_high = 0, saw_drop = 0;
        for (int i = 1; i <= 14; i++) begin
            sa_raw = (i <= D - 1);
            tick();
            if (Sa === 1'b1 || sa_rise === 1'b1) saw_high = 1;
        end
        if (saw_high !== 1'b0) begin
            errors++;
            $display("FAIL glitch_high: short pulse reached Sa (seen=%b), required 0", saw_high);
        end
        checks++;
        sa_raw = 1;
        repeat (10) tick();
        for (int i = 1; i <= 15; i++) begin
            sa_raw = (i > D - 1);
            tick();
            if (Sa !== 1'b1) saw_drop = 1;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL glitch_model: cycle %0d outputs=%b model=%b", i, obs(), expv());
            end
            checks++;
        end
        if (saw_drop !== 1'b0) begin
            errors++;
            $display("FAIL glitch_drop: short dropout reached Sa (dropped=%b), required 0", saw_drop);
        end
        checks++;
        sa_raw = 0;
        repeat (20) tick();
    endtask

    task automatic test_simultaneous();
        int ta = 0, tb = 0, tf = 0;
        bit sa_fell = 0;
        sa_raw = 1;
        for (int i = 1; i <= 24; i++) begin
            sb_raw = (i <= 10);
            tick();
            if (ta == 0 && Sa === 1'b1) ta = i;
            if (tb == 0 && Sb === 1'b1) tb = i;
            if (tf == 0 && i > 10 && Sb === 1'b0) tf = i - 10;
            if (ta != 0 && Sa !== 1'b1) sa_fell = 1;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL simul_model: cycle %0d outputs=%b model=%b", i, obs(), expv());
            end
            checks++;
        end
        if (ta != D + 2 || tb != D + 2) begin
            errors++;
            $display("FAIL simul_rise: Sa at %0d Sb at %0d, required both %0d", ta, tb, D + 2);
        end
        checks++;
        if (tf != D + 2 || sa_fell !== 1'b0) begin
            errors++;
            $display("FAIL simul_indep: Sb fell after %0d Sa_fell=%b, required %0d and 0", tf, sa_fell, D + 2);
        end
        checks++;
        sa_raw = 0; sb_raw = 0;
        repeat (20) tick();
    endtask

    task automatic test_reset_mid_qual();
        int t_rise = 0;
        sa_raw = 1;
        repeat (2) tick();
        reset = 1;
        tick();
        reset = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (t_rise == 0 && Sa === 1'b1) t_rise = i;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL midqual_model: cycle %0d outputs=%b model=%b", i, obs(), expv());
            end
            checks++;
        end
        if (t_rise != D + 2) begin
            errors++;
            $display("FAIL midqual_latency: Sa rose after %0d cycles, required %0d", t_rise, D + 2);
        end
        checks++;
        sa_raw = 0;
        repeat (20) tick();
    endtask

    task automatic test_pulse_width();
        int high = 0;
`ifdef SENSOR_STRETCH_EN
        int want = H;
`else
        int want = 5;
`endif
        for (int i = 1; i <= 24; i++) begin
            sa_raw = (i <= 5);
            tick();
            if (Sa === 1'b1) high++;
        end
        if (high != want) begin
            errors++;
            $display("FAIL pulse_width: Sa high %0d cycles, required %0d", high, want);
        end
        checks++;
        sa_raw = 0;
        repeat (4) tick();
    endtask

    task automatic test_random();
        int run_a = 0, run_b = 0;
        for (int i = 0; i < 1500; i++) begin
            if (run_a == 0) begin sa_raw = ~sa_raw; run_a = $urandom_range(1, 2 * D + 1); end
            if (run_b == 0) begin sb_raw = ~sb_raw; run_b = $urandom_range(1, 2 * D + 1); end
            run_a--; run_b--;
            reset = ($urandom_range(0, 199) == 0);
            tick();
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL random_model: cycle %0d outputs=%b model=%b", i, obs(), expv());
            end
            checks++;
        end
        reset = 0;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_simultaneous();
        test_reset_mid_qual();
        test_pulse_width();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
